decode_writeback: RTL and testbench
===================================

# decode_writeback

Y86-64 decode/writeback stage for the sequential processor. It sits directly downstream of fetch. It takes icode/rA/rB, selects source and destination registers, and reads valA/valB combinationally from a 15-entry × 64-bit register file. At the clock edge it commits valE/valM from execute and memory. It also holds a sticky processor status and a retired-instruction counter, and freezes all architectural state once the machine stops.

## Interface
- `REG_W`, default 64: register and data width.
- `NREG`, default 15: architectural registers; ID 4'hF means "none".
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icode`  in  4  instruction code from fetch.
- `rA`, `rB`  in  4 each  register specifiers from fetch.
- `cnd`  in  1  condition result from execute; gates the cmovxx write.
- `valE`  in  64  execute result.
- `valM`  in  64  memory read result.
- `wb_en`  in  1  current instruction completes this cycle.
- `halt`, `invalid_instr`, `imem_error`, `dmem_error`  in  1 each  exception flags for the current instruction.
- `valA`, `valB`  out  64  decoded operands (combinational).
- `srcA`, `srcB`, `dstE`, `dstM`  out  4 each  selected register IDs (combinational).
- `stat`  out  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- `retired`  out  64  count of committed instructions.

## Operation
- srcA:
  - rA for cmovxx(2), rmmovq(4), opq(6), pushq(A).
  - 4 (%rsp) for popq(B), ret(9).
  - F otherwise.
- srcB:
  - rB for opq, rmmovq, mrmovq(5).
  - 4 for pushq, popq, call(8), ret.
  - F otherwise.
- dstE:
  - rB for irmovq(3) and opq.
  - rB for cmovxx only when cnd=1, otherwise F.
  - 4 for pushq, popq, call, ret.
  - F otherwise.
- dstM: rA for mrmovq and popq; F otherwise.
- Reads:
  - valA = R[srcA] and valB = R[srcB], taken from the current (pre-edge) contents.
  - ID F, or any ID ≥ NREG, reads 0.
- Writes:
  - Happen on the rising edge when wb_en=1 and the state is RUN.
  - Write R[dstE] ← valE, then R[dstM] ← valM.
  - Writes to ID F are dropped.
  - If dstE == dstM (popq %rsp), valM wins.
- Status is a two-state machine, RUN and STOP:
  - RUN, edge with wb_en=1: exception priority is imem_error→ADR, invalid_instr→INS, dmem_error→ADR, halt→HLT; otherwise AOK.
  - Any non-AOK result moves to STOP. The faulting instruction's register writes are suppressed, and `retired` does not increment.
  - RUN with wb_en=0 holds its state.
  - STOP is absorbing until reset. No register writes, no counter change, and stat holds its code.
- `retired` increments by 1 on each committed AOK instruction. It wraps from 2^64−1 to 0.

## Timing
- Asynchronous reset (rst_n low): all R[i]=0, stat=AOK, state=RUN, retired=0.
- Reset release is synchronous to clk; the first commit can occur on the first rising edge after rst_n deasserts.
- Decode path is zero-latency combinational: icode/rA/rB → src/dst → valA/valB.
- A write becomes visible on valA/valB immediately after the committing edge (one-cycle write latency). There is no internal bypass, so same-cycle read-after-write returns the old value.
- If rst_n asserts mid-cycle, all state clears at once; a coincident edge does not commit.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants: HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - Register IDs RRSP=4 and RNONE=4'hF.
  - Stat codes SAOK, SHLT, SADR, SINS.
- One sub-module, `regfile`: two combinational read ports, two write ports with port M taking priority, asynchronous clear.
- Source/destination selection, the status FSM and the counter live in `decode_writeback`.

## Test plan
- **Reset:** rst_n=0 with random inputs → stat=1, retired=0, valA=valB=0 for every srcA/srcB.
- **irmovq then rmmovq:**
  - icode=3, rB=2, valE=0x1234, wb_en=1 → next cycle, icode=4, rA=2 gives srcA=2, valA=0x1234.
  - retired=1.
- **popq %rsp:**
  - icode=B, rA=4, valE=0x100, valM=0xBEEF → R[4]=0xBEEF.
  - dstE=dstM=4.
- **cmovxx gating:**
  - icode=2, rA=1, rB=3, cnd=0 → dstE=F, R[3] unchanged.
  - Same with cnd=1 → R[3]=valE.
- **Stop on halt:**
  - icode=0, halt=1, wb_en=1 → stat=2.
  - A later irmovq with wb_en=1 leaves registers and retired frozen.
  - rst_n pulse returns stat=1.
- **Exception priority:** imem_error=1 and invalid_instr=1 on the same commit → stat=3, no write, retired unchanged.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes,
// register IDs, status codes and state encodings.
package y86_pkg;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] CMOVXX = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } state_t;

  function automatic stat_t exc_stat(
    input logic imem,
    input logic ins,
    input logic dmem,
    input logic hlt
  );
    if (imem)      return SADR;
    else if (ins)  return SINS;
    else if (dmem) return SADR;
    else if (hlt)  return SHLT;
    else           return SAOK;
  endfunction

endpackage

// File: rtl/decode_writeback_if.sv
// Fetch/execute/memory side bundle of the
// decode/writeback stage.
interface decode_writeback_if #(
  parameter int REG_W = 64
) ();

  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             cnd;
  logic [REG_W-1:0] valE;
  logic [REG_W-1:0] valM;
  logic             wb_en;
  logic             halt;
  logic             invalid_instr;
  logic             imem_error;
  logic             dmem_error;
  logic [REG_W-1:0] valA;
  logic [REG_W-1:0] valB;
  logic [3:0]       srcA;
  logic [3:0]       srcB;
  logic [3:0]       dstE;
  logic [3:0]       dstM;
  logic [2:0]       stat;
  logic [63:0]      retired;

  modport master (
    output icode, rA, rB, cnd,
    output valE, valM, wb_en,
    output halt, invalid_instr,
    output imem_error, dmem_error,
    input  valA, valB,
    input  srcA, srcB, dstE, dstM,
    input  stat, retired
  );

  modport slave (
    input  icode, rA, rB, cnd,
    input  valE, valM, wb_en,
    input  halt, invalid_instr,
    input  imem_error, dmem_error,
    output valA, valB,
    output srcA, srcB, dstE, dstM,
    output stat, retired
  );

endinterface

// File: rtl/decode_writeback_regfile.sv
// Register file: two async read ports, two write
// ports (M wins on conflict), async clear.
module regfile #(
  parameter int REG_W = 64,
  parameter int NREG  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_a,
  input  logic [3:0]       id_b,
  output logic [REG_W-1:0] rd_a,
  output logic [REG_W-1:0] rd_b,
  input  logic             we_e,
  input  logic [3:0]       id_e,
  input  logic [REG_W-1:0] d_e,
  input  logic             we_m,
  input  logic [3:0]       id_m,
  input  logic [REG_W-1:0] d_m
);

  logic [REG_W-1:0] r [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && id_m == 4'(i))
          r[i] <= d_m;
        else if (we_e && id_e == 4'(i))
          r[i] <= d_e;
      end
    end
  end

  // IDs outside the file (incl. RNONE) read 0
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (id_a == 4'(i)) rd_a = r[i];
      if (id_b == 4'(i)) rd_b = r[i];
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback: register selection,
// register file commit, status FSM, retire count.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int REG_W = 64,
  parameter int NREG  = 15
) (
  input logic clk,
  input logic rst_n,
  decode_writeback_if.slave bus
);

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  always_comb begin
    src_a = RNONE;
    unique case (1'b1)
      bus.icode == CMOVXX,
      bus.icode == RMMOVQ,
      bus.icode == OPQ,
      bus.icode == PUSHQ: src_a = bus.rA;
      bus.icode == POPQ,
      bus.icode == RET:   src_a = RRSP;
      default:            src_a = RNONE;
    endcase
  end

  always_comb begin
    src_b = RNONE;
    unique case (1'b1)
      bus.icode == OPQ,
      bus.icode == RMMOVQ,
      bus.icode == MRMOVQ: src_b = bus.rB;
      bus.icode == PUSHQ,
      bus.icode == POPQ,
      bus.icode == CALL,
      bus.icode == RET:    src_b = RRSP;
      default:             src_b = RNONE;
    endcase
  end

  always_comb begin
    dst_e = RNONE;
    unique case (1'b1)
      bus.icode == IRMOVQ,
      bus.icode == OPQ:    dst_e = bus.rB;
      bus.icode == CMOVXX:
        dst_e = bus.cnd ? bus.rB : RNONE;
      bus.icode == PUSHQ,
      bus.icode == POPQ,
      bus.icode == CALL,
      bus.icode == RET:    dst_e = RRSP;
      default:             dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    unique case (1'b1)
      bus.icode == MRMOVQ,
      bus.icode == POPQ: dst_m = bus.rA;
      default:           dst_m = RNONE;
    endcase
  end

  state_t      state_q, state_d;
  stat_t       stat_q, stat_d;
  logic [63:0] ret_q;
  logic        commit;
  stat_t       exc;

  assign exc = exc_stat(bus.imem_error,
                        bus.invalid_instr,
                        bus.dmem_error,
                        bus.halt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stat_q  <= SAOK;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      if (commit)
        ret_q <= ret_q + 64'd1;
    end
  end

  // A faulting instruction stops the machine
  // without committing anything.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    commit  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.wb_en) begin
          stat_d = exc;
          if (exc != SAOK)
            state_d = STOP;
          else
            commit = 1'b1;
        end
      end
      STOP: begin
        state_d = STOP;
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  regfile #(
    .REG_W (REG_W),
    .NREG  (NREG)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .id_a  (src_a),
    .id_b  (src_b),
    .rd_a  (bus.valA),
    .rd_b  (bus.valB),
    .we_e  (commit && dst_e != RNONE),
    .id_e  (dst_e),
    .d_e   (bus.valE),
    .we_m  (commit && dst_m != RNONE),
    .id_m  (dst_m),
    .d_m   (bus.valM)
  );

  assign bus.srcA    = src_a;
  assign bus.srcB    = src_b;
  assign bus.dstE    = dst_e;
  assign bus.dstM    = dst_m;
  assign bus.stat    = stat_q;
  assign bus.retired = ret_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: vector
// table plus exception/stop/reset sequences.
module tb_decode_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decode_writeback_if #(.REG_W(64)) bus ();

  decode_writeback #(
    .REG_W (64),
    .NREG  (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  ic;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        cnd;
    logic [63:0] ve;
    logic [63:0] vm;
    logic        wb;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic [63:0] va;
    logic [63:0] vb;
    logic [63:0] ret;
  } vec_t;

  vec_t v [14];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.icode = 4'h1;
    bus.rA = 4'hF;
    bus.rB = 4'hF;
    bus.cnd = 1'b0;
    bus.valE = '0;
    bus.valM = '0;
    bus.wb_en = 1'b0;
    bus.halt = 1'b0;
    bus.invalid_instr = 1'b0;
    bus.imem_error = 1'b0;
    bus.dmem_error = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_ins(input logic [3:0] ic,
                         input logic [3:0] ra,
                         input logic [3:0] rb,
                         input logic [63:0] ve,
                         input logic wb);
    idle();
    bus.icode = ic;
    bus.rA = ra;
    bus.rB = rb;
    bus.valE = ve;
    bus.wb_en = wb;
  endtask

  task automatic read_reg(input logic [3:0] id,
                          input logic [63:0] exp,
                          input string nm);
    set_ins(4'h4, id, 4'hF, 64'h0, 1'b0);
    #1;
    check(nm, bus.valA, exp);
  endtask

  initial begin
    v[0]  = '{4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0,
              1'b1, 4'hF, 4'hF, 4'h2, 4'hF,
              64'h0, 64'h0, 64'd1};
    v[1]  = '{4'h4, 4'h2, 4'h4, 1'b0, 64'h0, 64'h0,
              1'b1, 4'h2, 4'h4, 4'hF, 4'hF,
              64'h1234, 64'h0, 64'd2};
    v[2]  = '{4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0,
              1'b1, 4'hF, 4'hF, 4'h4, 4'hF,
              64'h0, 64'h0, 64'd3};
    v[3]  = '{4'h6, 4'h2, 4'h4, 1'b0, 64'h1334, 64'h0,
              1'b1, 4'h2, 4'h4, 4'h4, 4'hF,
              64'h1234, 64'h100, 64'd4};
    v[4]  = '{4'hA, 4'h2, 4'hF, 1'b0, 64'h1320, 64'h0,
              1'b1, 4'h2, 4'h4, 4'h4, 4'hF,
              64'h1234, 64'h1334, 64'd5};
    v[5]  = '{4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hBEEF,
              1'b1, 4'h4, 4'h4, 4'h4, 4'h4,
              64'h1320, 64'h1320, 64'd6};
    v[6]  = '{4'h5, 4'h5, 4'h2, 1'b0, 64'h1234, 64'h55,
              1'b1, 4'hF, 4'h2, 4'hF, 4'h5,
              64'h0, 64'h1234, 64'd7};
    v[7]  = '{4'h2, 4'h1, 4'h3, 1'b0, 64'h99, 64'h0,
              1'b1, 4'h1, 4'hF, 4'hF, 4'hF,
              64'h0, 64'h0, 64'd8};
    v[8]  = '{4'h2, 4'h5, 4'h3, 1'b1, 64'h55, 64'h0,
              1'b1, 4'h5, 4'hF, 4'h3, 4'hF,
              64'h55, 64'h0, 64'd9};
    v[9]  = '{4'h8, 4'hF, 4'hF, 1'b0, 64'hBEE7, 64'h0,
              1'b1, 4'hF, 4'h4, 4'h4, 4'hF,
              64'h0, 64'hBEEF, 64'd10};
    v[10] = '{4'h9, 4'hF, 4'hF, 1'b0, 64'hBEEF, 64'h77,
              1'b1, 4'h4, 4'h4, 4'h4, 4'hF,
              64'hBEE7, 64'hBEE7, 64'd11};
    v[11] = '{4'h7, 4'h1, 4'h2, 1'b1, 64'h0, 64'h0,
              1'b1, 4'hF, 4'hF, 4'hF, 4'hF,
              64'h0, 64'h0, 64'd12};
    v[12] = '{4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0,
              1'b0, 4'hF, 4'hF, 4'h6, 4'hF,
              64'h0, 64'h0, 64'd12};
    v[13] = '{4'h6, 4'h3, 4'h5, 1'b0, 64'hAA, 64'h0,
              1'b1, 4'h3, 4'h5, 4'h5, 4'hF,
              64'h55, 64'h55, 64'd13};

    // reset with random inputs
    idle();
    bus.icode = 4'($urandom);
    bus.rA = 4'($urandom);
    bus.rB = 4'($urandom);
    bus.valE = {$urandom, $urandom};
    bus.valM = {$urandom, $urandom};
    bus.wb_en = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_stat", 64'(bus.stat), 64'd1);
    check("rst_retired", bus.retired, 64'd0);
    for (int i = 0; i < 16; i++) begin
      set_ins(4'h6, 4'(i), 4'(i), 64'h0, 1'b0);
      #1;
      check($sformatf("rst_valA_%0d", i),
            bus.valA, 64'h0);
      check($sformatf("rst_valB_%0d", i),
            bus.valB, 64'h0);
    end
    rst_n = 1'b1;
    idle();
    tick();

    // vector table
    for (int k = 0; k < 14; k++) begin
      idle();
      bus.icode = v[k].ic;
      bus.rA = v[k].ra;
      bus.rB = v[k].rb;
      bus.cnd = v[k].cnd;
      bus.valE = v[k].ve;
      bus.valM = v[k].vm;
      bus.wb_en = v[k].wb;
      #1;
      check($sformatf("v%0d_srcA", k),
            64'(bus.srcA), 64'(v[k].sa));
      check($sformatf("v%0d_srcB", k),
            64'(bus.srcB), 64'(v[k].sb));
      check($sformatf("v%0d_dstE", k),
            64'(bus.dstE), 64'(v[k].de));
      check($sformatf("v%0d_dstM", k),
            64'(bus.dstM), 64'(v[k].dm));
      check($sformatf("v%0d_valA", k),
            bus.valA, v[k].va);
      check($sformatf("v%0d_valB", k),
            bus.valB, v[k].vb);
      tick();
      check($sformatf("v%0d_retired", k),
            bus.retired, v[k].ret);
      check($sformatf("v%0d_stat", k),
            64'(bus.stat), 64'd1);
    end
    read_reg(4'h3, 64'h55, "r3_cmov");
    read_reg(4'h4, 64'hBEEF, "r4_final");
    read_reg(4'h5, 64'hAA, "r5_final");
    read_reg(4'h6, 64'h0, "r6_nowb");
    read_reg(4'h1, 64'h0, "r1_untouched");

    // imem + invalid on same commit -> ADR
    set_ins(4'h3, 4'hF, 4'h6, 64'hDEAD, 1'b1);
    bus.imem_error = 1'b1;
    bus.invalid_instr = 1'b1;
    tick();
    check("prio_stat", 64'(bus.stat), 64'd3);
    check("prio_retired", bus.retired, 64'd13);
    read_reg(4'h6, 64'h0, "prio_nowrite");
    set_ins(4'h3, 4'hF, 4'h7, 64'h1, 1'b1);
    tick();
    check("stop_stat", 64'(bus.stat), 64'd3);
    check("stop_retired", bus.retired, 64'd13);
    read_reg(4'h7, 64'h0, "stop_nowrite");

    // mid-cycle asynchronous reset
    set_ins(4'h4, 4'h5, 4'h4, 64'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stat", 64'(bus.stat), 64'd1);
    check("arst_retired", bus.retired, 64'd0);
    check("arst_valA", bus.valA, 64'h0);
    check("arst_valB", bus.valB, 64'h0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;

    // halt stops the machine
    set_ins(4'h3, 4'hF, 4'h1, 64'h7, 1'b1);
    tick();
    check("h_retired1", bus.retired, 64'd1);
    set_ins(4'h0, 4'hF, 4'hF, 64'h0, 1'b1);
    bus.halt = 1'b1;
    tick();
    check("h_stat", 64'(bus.stat), 64'd2);
    check("h_retired2", bus.retired, 64'd1);
    set_ins(4'h3, 4'hF, 4'h1, 64'h9, 1'b1);
    tick();
    tick();
    check("h_frozen_stat", 64'(bus.stat), 64'd2);
    check("h_frozen_ret", bus.retired, 64'd1);
    read_reg(4'h1, 64'h7, "h_frozen_r1");
    do_reset();
    check("h_reset_stat", 64'(bus.stat), 64'd1);

    // invalid_instr alone -> INS
    set_ins(4'h3, 4'hF, 4'h2, 64'h5, 1'b1);
    bus.invalid_instr = 1'b1;
    tick();
    check("ins_stat", 64'(bus.stat), 64'd4);
    read_reg(4'h2, 64'h0, "ins_nowrite");
    do_reset();

    // dmem_error beats halt -> ADR
    set_ins(4'h0, 4'hF, 4'hF, 64'h0, 1'b1);
    bus.dmem_error = 1'b1;
    bus.halt = 1'b1;
    tick();
    check("dmem_stat", 64'(bus.stat), 64'd3);
    check("dmem_retired", bus.retired, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
